// File: rtl/fibo_bcd_display.sv
// Captures a 16-bit Fibonacci result on the rising edge of done, converts it to five
// BCD digits with a one-bit-per-cycle double-dabble engine and drives 7-segment patterns.
module fibo_bcd_display #(
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] fibo_out,
    input  logic        done,
    output logic        busy,
    output logic        conv_valid,
    output logic [19:0] bcd_out,
    output logic [6:0]  seg4,
    output logic [6:0]  seg3,
    output logic [6:0]  seg2,
    output logic [6:0]  seg1,
    output logic [6:0]  seg0
);
    typedef enum logic [1:0] {IDLE, CONV, PUBLISH} state_t;

    localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t      state_reg, state_next;
    logic        done_q;
    logic        start;
    logic        load, shift, publish;
    logic [35:0] sh_reg;
    logic [4:0]  cnt_reg;
    logic [19:0] bcd_reg;
    logic        conv_valid_reg;
    logic [19:0] bcd_adj;
    logic [35:0] sh_shifted;
    logic [6:0]  seg_reg  [5];
    logic [6:0]  seg_next [5];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'd0: s = 7'h3F;
            4'd1: s = 7'h06;
            4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;
            4'd4: s = 7'h66;
            4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;
            4'd7: s = 7'h07;
            4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign start = done & ~done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            done_q    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_q    <= done;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (cnt_reg == 5'd1) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load    = (state_reg == IDLE) && start;
        shift   = (state_reg == CONV);
        publish = (state_reg == PUBLISH);
        busy    = (state_reg != IDLE);
    end

    // Add-3 correction on every BCD nibble, then shift the whole register left by one.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = sh_reg[16 + 4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    assign sh_shifted = {bcd_adj[18:0], sh_reg[15:0], 1'b0};

    // Digit k>0 is blanked when it and every more-significant digit are zero.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_seg
            logic       blank;
            logic [6:0] pattern;
            if (gi == 0) begin : g_units
                assign blank = 1'b0;
            end else begin : g_upper
                assign blank = BLANK_LZ && (sh_reg[35 : 16 + 4*gi] == '0);
            end
            assign pattern      = blank ? 7'h00 : seg_decode(sh_reg[16 + 4*gi +: 4]);
            assign seg_next[gi] = SEG_ACTIVE_LOW ? ~pattern : pattern;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_reg         <= '0;
            cnt_reg        <= '0;
            bcd_reg        <= '0;
            conv_valid_reg <= 1'b0;
            for (int i = 0; i < 5; i++) seg_reg[i] <= SEG_BLANK;
        end else begin
            conv_valid_reg <= publish;
            if (load) begin
                sh_reg  <= {20'b0, fibo_out};
                cnt_reg <= 5'd16;
            end else if (shift) begin
                sh_reg  <= sh_shifted;
                cnt_reg <= cnt_reg - 5'd1;
            end
            if (publish) begin
                bcd_reg <= sh_reg[35:16];
                for (int i = 0; i < 5; i++) seg_reg[i] <= seg_next[i];
            end
        end
    end

    assign conv_valid = conv_valid_reg;
    assign bcd_out    = bcd_reg;
    assign seg0       = seg_reg[0];
    assign seg1       = seg_reg[1];
    assign seg2       = seg_reg[2];
    assign seg3       = seg_reg[3];
    assign seg4       = seg_reg[4];
endmodule

// File: tb/tb_fibo_bcd_display.sv
// Directed bench for fibo_bcd_display: default, no-blanking and active-high-segment instances.
module tb_fibo_bcd_display;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] fibo_out;
    logic        done;

    logic        busy_a, cv_a, busy_b, cv_b, busy_c, cv_c;
    logic [19:0] bcd_a, bcd_b, bcd_c;
    logic [6:0]  a4, a3, a2, a1, a0;
    logic [6:0]  b4, b3, b2, b1, b0;
    logic [6:0]  c4, c3, c2, c1, c0;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;
    int busy_cycles;
    int pulses;

    always #5 clk = ~clk;

    fibo_bcd_display dut_a (
        .clk(clk), .reset_n(reset_n), .fibo_out(fibo_out), .done(done),
        .busy(busy_a), .conv_valid(cv_a), .bcd_out(bcd_a),
        .seg4(a4), .seg3(a3), .seg2(a2), .seg1(a1), .seg0(a0)
    );

    fibo_bcd_display #(.BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .fibo_out(fibo_out), .done(done),
        .busy(busy_b), .conv_valid(cv_b), .bcd_out(bcd_b),
        .seg4(b4), .seg3(b3), .seg2(b2), .seg1(b1), .seg0(b0)
    );

    fibo_bcd_display #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_c (
        .clk(clk), .reset_n(reset_n), .fibo_out(fibo_out), .done(done),
        .busy(busy_c), .conv_valid(cv_c), .bcd_out(bcd_c),
        .seg4(c4), .seg3(c3), .seg2(c2), .seg1(c1), .seg0(c0)
    );

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge N has just passed; count edges until conv_valid, tallying busy cycles.
    task automatic wait_result();
        lat = 0;
        busy_cycles = busy_a ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy_a) busy_cycles++;
            if (cv_a) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic convert(input logic [15:0] val);
        done = 1'b0;
        tick();
        fibo_out = val;
        done = 1'b1;
        tick();
        wait_result();
        $display("conversion fibo_out=%0d latency=%0d bcd_out=%h", val, lat, bcd_a);
    endtask

    initial begin
        reset_n  = 1'b0;
        done     = 1'b0;
        fibo_out = 16'd0;
        tick();
        tick();
        check("reset_busy", {19'b0, busy_a}, 20'h0);
        check("reset_cv", {19'b0, cv_a}, 20'h0);
        check("reset_bcd", bcd_a, 20'h0);
        check("reset_seg0", {13'b0, a0}, 20'h7F);
        check("reset_seg4", {13'b0, a4}, 20'h7F);
        check("reset_hi_seg0", {13'b0, c0}, 20'h00);
        reset_n = 1'b1;
        tick();

        convert(16'd0);
        check("zero_latency", lat, 17);
        check("zero_bcd", bcd_a, 20'h00000);
        check("zero_seg0", {13'b0, a0}, 20'h40);
        check("zero_seg1", {13'b0, a1}, 20'h7F);
        check("zero_seg4", {13'b0, a4}, 20'h7F);
        tick();
        check("zero_cv_one_cycle", {19'b0, cv_a}, 20'h0);

        convert(16'd6765);
        check("f20_latency", lat, 17);
        check("f20_busy_cycles", busy_cycles, 17);
        check("f20_bcd", bcd_a, 20'h06765);
        check("f20_seg4", {13'b0, a4}, 20'h7F);
        check("f20_seg3", {13'b0, a3}, 20'h02);
        check("f20_seg2", {13'b0, a2}, 20'h78);
        check("f20_seg1", {13'b0, a1}, 20'h02);
        check("f20_seg0", {13'b0, a0}, 20'h12);

        convert(16'hFFFF);
        check("max_bcd", bcd_a, 20'h65535);
        check("max_seg4", {13'b0, a4}, 20'h02);
        check("max_seg1", {13'b0, a1}, 20'h30);

        convert(16'd46368);
        check("f24_bcd", bcd_a, 20'h46368);

        convert(16'd89);
        check("f11_bcd", bcd_a, 20'h00089);
        check("f11_seg2", {13'b0, a2}, 20'h7F);
        check("f11_seg1", {13'b0, a1}, 20'h00);
        check("f11_seg0", {13'b0, a0}, 20'h10);
        check("f11_nolz_seg4", {13'b0, b4}, 20'h40);
        check("f11_nolz_seg3", {13'b0, b3}, 20'h40);
        check("f11_nolz_seg2", {13'b0, b2}, 20'h40);

        convert(16'd8);
        check("eight_hi_seg0", {13'b0, c0}, 20'h7F);
        check("eight_hi_seg1", {13'b0, c1}, 20'h00);
        check("eight_hi_seg4", {13'b0, c4}, 20'h00);
        check("eight_bcd_hi", bcd_c, 20'h00008);

        // done stays high: no further conversions regardless of fibo_out.
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            fibo_out = 16'($urandom);
            tick();
            if (cv_a || busy_a) pulses++;
        end
        $display("hold done high 100 cycles: activity=%0d bcd_out=%h", pulses, bcd_a);
        check("hold_no_activity", pulses, 0);
        check("hold_bcd", bcd_a, 20'h00008);

        // Rising edge of done during CONV is ignored; fibo_out only matters at load.
        done = 1'b0;
        tick();
        fibo_out = 16'd1234;
        done = 1'b1;
        tick();
        fibo_out = 16'd9999;
        pulses = 0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 4) done = 1'b0;
            if (k == 5) done = 1'b1;
            tick();
            if (cv_a) begin
                pulses++;
                if (lat == 0) lat = k;
            end
        end
        $display("mid-conv done pulse: pulses=%0d latency=%0d bcd_out=%h", pulses, lat, bcd_a);
        check("glitch_pulses", pulses, 1);
        check("glitch_latency", lat, 17);
        check("glitch_bcd", bcd_a, 20'h01234);

        // Reset during the 8th CONV cycle with done held high.
        done = 1'b0;
        tick();
        fibo_out = 16'd4321;
        done = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();
        reset_n = 1'b0;
        #1;
        $display("reset mid-conv: busy=%0b cv=%0b bcd_out=%h seg0=%h", busy_a, cv_a, bcd_a, a0);
        check("midrst_busy", {19'b0, busy_a}, 20'h0);
        check("midrst_bcd", bcd_a, 20'h0);
        check("midrst_seg0", {13'b0, a0}, 20'h7F);
        check("midrst_seg3", {13'b0, a3}, 20'h7F);
        tick();
        reset_n = 1'b1;
        tick();
        wait_result();
        $display("restart after reset: latency=%0d bcd_out=%h", lat, bcd_a);
        check("restart_latency", lat, 17);
        check("restart_bcd", bcd_a, 20'h04321);
        check("restart_seg3", {13'b0, a3}, 20'h19);
        check("restart_seg0", {13'b0, a0}, 20'h79);
        check("restart_seg4", {13'b0, a4}, 20'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
